// File: rtl/uart_tx.sv
// UART transmitter: sends N data bits LSB first, with an optional even-parity bit.
// Bit timing is PSCALER*DIV sysclk cycles per bit; the line idles high.
module uart_tx #(
    parameter int N       = 8,
    parameter int PSCALER = 1,
    parameter int DIV     = 10
) (
    input  logic         sysclk,
    input  logic         reset_n,
    input  logic         parity_i,
    input  logic         tx_start_i,
    input  logic [N-1:0] tx_data_i,
    output logic         tx_o,
    output logic         tx_busy_o,
    output logic         tx_end_o
);

    localparam int PW = (PSCALER > 1) ? $clog2(PSCALER) : 1;
    localparam int BW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [PW-1:0] PS_LAST  = PW'(PSCALER - 1);
    localparam logic [BW-1:0] DIV_LAST = BW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_BITS   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    function automatic logic even_parity(input logic [N-1:0] d);
        return ^d;
    endfunction

    state_t        r_state;
    logic [PW-1:0] r_ps_cnt;
    logic [BW-1:0] r_bit_cnt;
    logic [IW-1:0] r_idx;
    logic [N-1:0]  r_shift;
    logic          r_par_en;
    logic          r_par;
    logic          r_tx;
    logic          r_busy;
    logic          r_end;

    logic          w_tick;
    logic          w_bit_end;
    logic [N-1:0]  w_shift_next;

    assign w_tick       = (r_ps_cnt == PS_LAST);
    assign w_bit_end    = w_tick && (r_bit_cnt == DIV_LAST);
    assign w_shift_next = r_shift >> 1;

    // Frame sequencer with baud counters; every output comes straight from a register.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_ps_cnt  <= '0;
            r_bit_cnt <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_par_en  <= 1'b0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_end     <= 1'b0;
        end else begin
            r_end <= 1'b0;
            if (r_state != S_IDLE) begin
                r_ps_cnt <= w_tick ? '0 : r_ps_cnt + PW'(1);
                if (w_tick) begin
                    r_bit_cnt <= (r_bit_cnt == DIV_LAST) ? '0 : r_bit_cnt + BW'(1);
                end
            end
            case (r_state)
                S_IDLE: begin
                    r_tx      <= 1'b1;
                    r_busy    <= 1'b0;
                    r_ps_cnt  <= '0;
                    r_bit_cnt <= '0;
                    if (tx_start_i) begin
                        r_state  <= S_START;
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
                        r_shift  <= tx_data_i;
                        r_par_en <= parity_i;
                        r_par    <= even_parity(tx_data_i);
                        r_idx    <= '0;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_state <= S_BITS;
                        r_tx    <= r_shift[0];
                        r_idx   <= '0;
                    end
                end
                S_BITS: begin
                    if (w_bit_end) begin
                        if (r_idx == IDX_LAST) begin
                            if (r_par_en) begin
                                r_state <= S_PARITY;
                                r_tx    <= r_par;
                            end else begin
                                r_state <= S_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_shift <= w_shift_next;
                            r_tx    <= w_shift_next[0];
                            r_idx   <= r_idx + IW'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_end   <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_tx      <= 1'b1;
                    r_busy    <= 1'b0;
                    r_ps_cnt  <= '0;
                    r_bit_cnt <= '0;
                end
            endcase
        end
    end

    assign tx_o      = r_tx;
    assign tx_busy_o = r_busy;
    assign tx_end_o  = r_end;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: frame shape, parity, ignored starts, back-to-back frames,
// async reset mid-frame, and a mid-bit sampling receiver on a PSCALER=4 instance.
module tb_uart_tx;

    logic       clk;
    logic       rst_n;
    logic       par, start;
    logic [7:0] data;
    logic       tx, busy, tend;
    logic       par4, start4;
    logic [7:0] data4;
    logic       tx4, busy4, tend4;

    int n_checks = 0;
    int n_errors = 0;
    int n_end    = 0;

    uart_tx #(.N(8), .PSCALER(1), .DIV(10)) u_dut (
        .sysclk(clk), .reset_n(rst_n), .parity_i(par), .tx_start_i(start),
        .tx_data_i(data), .tx_o(tx), .tx_busy_o(busy), .tx_end_o(tend)
    );

    uart_tx #(.N(8), .PSCALER(4), .DIV(10)) u_dut4 (
        .sysclk(clk), .reset_n(rst_n), .parity_i(par4), .tx_start_i(start4),
        .tx_data_i(data4), .tx_o(tx4), .tx_busy_o(busy4), .tx_end_o(tend4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tend) n_end <= n_end + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sends one frame on the PSCALER=1 instance and checks every cycle of every bit.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic exp_par,
                              input bit keep_start, input bit inject);
        logic [10:0] bits;
        logic [9:0]  s;
        int          nb;
        nb = p ? 11 : 10;
        bits = 11'h7FF;
        bits[0] = 1'b0;
        bits[8:1] = d;
        if (p) bits[9] = exp_par;
        data  = d;
        par   = p;
        start = 1'b1;
        @(posedge clk); #1;
        if (!keep_start) start = 1'b0;
        check("busy_at_start", busy, 1);
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < 10; j++) begin
                s[j] = tx;
                if (inject && b == 4 && j == 5) begin
                    start = 1'b1;
                    data  = 8'hFF;
                    par   = ~p;
                end
                if (inject && b == 4 && j == 6) start = 1'b0;
                @(posedge clk); #1;
            end
            check($sformatf("bit%0d_of_%0h", b, d), s, {10{bits[b]}});
        end
        check("end_pulse", tend, 1);
        check("busy_at_end", busy, 0);
    endtask

    // Sends one frame on the PSCALER=4 instance and decodes it by mid-bit sampling.
    task automatic send4(input logic [7:0] d, input logic p);
        logic [10:0] r;
        logic        err;
        int          nb;
        nb = p ? 11 : 10;
        r = '0;
        data4  = d;
        par4   = p;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        check("busy4_at_start", busy4, 1);
        for (int b = 0; b < nb; b++) begin
            repeat (20) begin @(posedge clk); #1; end
            r[b] = tx4;
            repeat (20) begin @(posedge clk); #1; end
        end
        err = (r[0] != 1'b0) || (r[nb-1] != 1'b1) || (p && (r[9] != ^r[8:1]));
        check($sformatf("rx_data_%0h", d), r[8:1], d);
        check("rx_err", err, 0);
        check("end4_pulse", tend4, 1);
    endtask

    initial begin
        int   e0;
        int   bad;
        logic [7:0] rd;
        rst_n = 1'b0; start = 1'b0; data = 8'h00; par = 1'b0;
        start4 = 1'b0; data4 = 8'h00; par4 = 1'b0;
        #22;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_end", tend, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk); #1;

        // 0x55 without parity, then pulse width of tx_end
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("end_one_cycle", tend, 0);

        // parity frames: 0xA5 has four ones, 0x07 has three
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b0);

        // start while busy ignored; then the line must stay idle
        repeat (5) @(posedge clk); #1;
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
        data = 8'h00;
        bad = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("no_second_frame", bad, 0);

        // back-to-back with start held high
        e0 = n_end;
        send_frame(8'h12, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("end_count", n_end - e0, 2);

        // async reset during d3 of 0x55
        repeat (4) @(posedge clk); #1;
        data = 8'h55; par = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (45) begin @(posedge clk); #1; end
        check("d3_before_reset", tx, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_end", tend, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("idle_after_rst", {tx, busy}, 2'b10);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);

        // loopback on the PSCALER=4 instance
        send4(8'h00, 1'b1);
        send4(8'hFF, 1'b0);
        for (int i = 0; i < 30; i++) begin
            rd = 8'($urandom_range(0, 255));
            send4(rd, 1'(i % 2));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
